hex_display_controller: RTL and testbench

Registered, multi-channel driver for the board's bank of active-low seven-segment displays. It generalises the static 32-bit hex readout to `DIGITS` digits and `CHANNELS` independently loadable sources. A debounced push-button or an auto-cycle timer selects which source is shown. Optional leading-zero blanking and per-digit blinking are provided. It sits between the processor's debug outputs (register file, PC, IR, memory data) and the Hex pins.

---
 rtl/hex_display_controller_if.sv | 28 ++
 rtl/hex_display_controller.sv | 193 +++++++++++++++++++
 tb/tb_hex_display_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_controller_if.sv
// Bundle of the source-side and display-side signals of hex_display_controller.
// The master drives sources and controls; the slave (the controller) drives the Hex pins.
interface hex_display_controller_if #(
  parameter int DIGITS   = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
);
  logic [CHANNELS*DIGITS*4-1:0] ch_data;
  logic [CHANNELS-1:0]          ch_load;
  logic                         freeze;
  logic                         sel_next;
  logic                         auto_en;
  logic                         blank_lz;
  logic [DIGITS-1:0]            blink_mask;
  logic [DIGITS*7-1:0]          seg_L;
  logic [CH_W-1:0]              cur_channel;
  logic                         blink_phase;

  modport master (
    output ch_data, ch_load, freeze, sel_next, auto_en, blank_lz, blink_mask,
    input  seg_L, cur_channel, blink_phase
  );

  modport slave (
    input  ch_data, ch_load, freeze, sel_next, auto_en, blank_lz, blink_mask,
    output seg_L, cur_channel, blink_phase
  );
endinterface

// File: rtl/hex_display_controller.sv
// Multi-channel registered driver for active-low seven-segment digits with channel select,
// leading-zero blanking and optional per-digit blinking (enabled by HEXDISP_BLINK_EN).
module hex_display_controller #(
  parameter int DIGITS      = 8,
  parameter int CHANNELS    = 4,
  parameter int CH_W        = 2,
  parameter int AUTO_TICKS  = 27_000_000,
  parameter int BLINK_TICKS = 6_750_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  hex_display_controller_if.slave  bus
);

  localparam int SW = 4 * DIGITS;
  localparam int AW = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [SW-1:0]        shadow_r [CHANNELS];
  logic                 sel_q_r;
  logic                 rise_s;
  logic [AW-1:0]        auto_cnt_r;
  logic                 advance_s;
  logic                 cnt_clear_s;
  logic [CH_W-1:0]      cur_channel_r;
  logic [CH_W-1:0]      chan_next_s;
  logic [DIGITS*7-1:0]  seg_r;
  logic [DIGITS*7-1:0]  seg_next_s;
  logic [SW-1:0]        cur_word_s;
  logic [DIGITS-1:0]    blink_gate_s;
  logic                 zero_above_s;

  // Active-low g..a glyph for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      4'hF:    g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign rise_s      = bus.sel_next & ~sel_q_r;
  assign chan_next_s = (cur_channel_r == CH_W'(CHANNELS - 1)) ? {CH_W{1'b0}}
                                                               : cur_channel_r + CH_W'(1);

  // Shadow capture and push-button edge history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_r[i] <= {SW{1'b0}};
      end
      sel_q_r <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.ch_load[i] && !bus.freeze) begin
          shadow_r[i] <= bus.ch_data[i*SW +: SW];
        end
      end
      sel_q_r <= bus.sel_next;
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_MANUAL;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Channel FSM next state: the mode follows auto_en on every edge.
  always_comb begin
    next_state_s = ST_MANUAL;
    case (state_r)
      ST_MANUAL: next_state_s = bus.auto_en ? ST_AUTO : ST_MANUAL;
      ST_AUTO:   next_state_s = bus.auto_en ? ST_AUTO : ST_MANUAL;
      default:   next_state_s = ST_MANUAL;
    endcase
  end

  // Channel FSM outputs; a terminal count coinciding with a press still advances once.
  always_comb begin
    advance_s   = 1'b0;
    cnt_clear_s = 1'b1;
    case (next_state_s)
      ST_AUTO: begin
        advance_s   = rise_s | (auto_cnt_r == AW'(AUTO_TICKS - 1));
        cnt_clear_s = advance_s;
      end
      ST_MANUAL: begin
        advance_s   = rise_s;
        cnt_clear_s = 1'b1;
      end
      default: begin
        advance_s   = 1'b0;
        cnt_clear_s = 1'b1;
      end
    endcase
  end

  // Auto-cycle counter and selected channel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      auto_cnt_r    <= {AW{1'b0}};
      cur_channel_r <= {CH_W{1'b0}};
    end else begin
      auto_cnt_r <= cnt_clear_s ? {AW{1'b0}} : auto_cnt_r + AW'(1);
      if (advance_s) begin
        cur_channel_r <= chan_next_s;
      end
    end
  end

`ifdef HEXDISP_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BW-1:0] blink_cnt_r;
  logic          blink_phase_r;

  // Free-running blink half-period timer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt_r   <= {BW{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (blink_cnt_r == BW'(BLINK_TICKS - 1)) begin
      blink_cnt_r   <= {BW{1'b0}};
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + BW'(1);
      blink_phase_r <= blink_phase_r;
    end
  end

  assign blink_gate_s    = {DIGITS{blink_phase_r}} & bus.blink_mask;
  assign bus.blink_phase = blink_phase_r;
`else
  logic unused_blink_s;
  assign unused_blink_s  = ^{bus.blink_mask, BLINK_TICKS[0]};
  assign blink_gate_s    = {DIGITS{1'b0}};
  assign bus.blink_phase = 1'b0;
`endif

  // Decode the shown word, scanning from the top so zero_above_s tracks leading zeros.
  always_comb begin
    cur_word_s   = shadow_r[cur_channel_r];
    zero_above_s = 1'b1;
    seg_next_s   = {(DIGITS*7){1'b1}};
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above_s = zero_above_s & (cur_word_s[4*k +: 4] == 4'h0);
      if ((bus.blank_lz && zero_above_s && (k != 0)) || blink_gate_s[k]) begin
        seg_next_s[7*k +: 7] = 7'b1111111;
      end else begin
        seg_next_s[7*k +: 7] = hex7(cur_word_s[4*k +: 4]);
      end
    end
  end

  // Registered segment outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_r <= {(DIGITS*7){1'b1}};
    end else begin
      seg_r <= seg_next_s;
    end
  end

  assign bus.seg_L       = seg_r;
  assign bus.cur_channel = cur_channel_r;

endmodule

// File: tb/tb_hex_display_controller.sv
// Self-checking bench for hex_display_controller: directed vector table, hand sequences
// and a randomized run against a cycle-level behavioural model.
module tb_hex_display_controller;

  localparam int DIGITS   = 8;
  localparam int CHANNELS = 4;
  localparam int CH_W     = 2;
  localparam int AT       = 8;
  localparam int BT       = 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [31:0] data;
    bit          lz;
    logic [55:0] seg;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] m_sh [CHANNELS];
  int          m_ch, m_auto, m_blink;
  bit          m_sel_q, m_phase;
  logic [55:0] m_seg;

  always #5 clk = ~clk;

  hex_display_controller_if #(.DIGITS(DIGITS), .CHANNELS(CHANNELS), .CH_W(CH_W)) bus ();

  hex_display_controller #(
    .DIGITS(DIGITS), .CHANNELS(CHANNELS), .CH_W(CH_W),
    .AUTO_TICKS(AT), .BLINK_TICKS(BT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected segments: find the most significant nonzero digit, blank above it and blink-gate.
  function automatic logic [55:0] exp_seg(input logic [31:0] d, input bit lz,
                                          input logic [7:0] mask, input bit ph);
    logic [55:0] r;
    int msd = 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (d[4*k +: 4] != 4'h0) msd = k;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if ((lz && k > msd) || (ph && mask[k])) r[7*k +: 7] = 7'h7F;
      else r[7*k +: 7] = GLYPH[d[4*k +: 4]];
    end
    return r;
  endfunction

  // Advance the model by one edge from the current inputs, clock the DUT and compare.
  task automatic tick();
    logic [55:0] nseg;
    logic [7:0]  mask_eff;
    bit          rise;
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) m_sh[i] = 32'h0;
      m_ch = 0; m_auto = 0; m_blink = 0; m_sel_q = 1'b0; m_phase = 1'b0;
      nseg = {56{1'b1}};
    end else begin
`ifdef HEXDISP_BLINK_EN
      mask_eff = bus.blink_mask;
`else
      mask_eff = 8'h00;
`endif
      nseg = exp_seg(m_sh[m_ch], bus.blank_lz, mask_eff, m_phase);
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.ch_load[i] && !bus.freeze) m_sh[i] = bus.ch_data[32*i +: 32];
      end
      rise = bus.sel_next && !m_sel_q;
      m_sel_q = bus.sel_next;
      if (bus.auto_en) begin
        if (rise || m_auto == AT - 1) begin
          m_ch = (m_ch + 1) % CHANNELS;
          m_auto = 0;
        end else begin
          m_auto++;
        end
      end else begin
        m_auto = 0;
        if (rise) m_ch = (m_ch + 1) % CHANNELS;
      end
`ifdef HEXDISP_BLINK_EN
      if (m_blink == BT - 1) begin
        m_blink = 0;
        m_phase = !m_phase;
      end else begin
        m_blink++;
      end
`endif
    end
    m_seg = nseg;
    @(posedge clk);
    #1;
    check("model_seg", 64'(bus.seg_L), 64'(m_seg));
    check("model_chan", 64'(bus.cur_channel), 64'(m_ch));
    check("model_phase", 64'(bus.blink_phase), 64'(m_phase));
  endtask

  initial begin
    vec_t        tbl [6];
    logic [55:0] last_seg;
    int          c0, blanks, expb;
    logic [31:0] r;

    tbl[0] = '{32'hDEADBEEF, 1'b0, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}};
    tbl[1] = '{32'h000000A5, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}};
    tbl[2] = '{32'h000000A5, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12}};
    tbl[3] = '{32'h00000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tbl[4] = '{32'h00F00000, 1'b1, {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[5] = '{32'h12345678, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};

    bus.ch_data = '0; bus.ch_load = '0; bus.freeze = 1'b0; bus.sel_next = 1'b0;
    bus.auto_en = 1'b0; bus.blank_lz = 1'b0; bus.blink_mask = '0;

    // Reset held for two edges, then released.
    reset_n = 1'b0;
    tick(); tick();
    check("rst_seg", 64'(bus.seg_L), 64'({56{1'b1}}));
    check("rst_chan", 64'(bus.cur_channel), 64'd0);
    reset_n = 1'b1;
    tick();
    check("release_seg", 64'(bus.seg_L), 64'({8{7'h40}}));

    // Directed loads, two edges from strobe to display.
    for (int v = 0; v < 6; v++) begin
      bus.ch_data = {4{tbl[v].data}};
      bus.ch_load = 4'hF;
      bus.blank_lz = tbl[v].lz;
      tick();
      bus.ch_load = 4'h0;
      tick();
      check($sformatf("vec%0d_seg", v), 64'(bus.seg_L), 64'(tbl[v].seg));
    end
    last_seg = tbl[5].seg;

    // Four single-cycle presses walk through every channel and wrap.
    for (int p = 0; p < 4; p++) begin
      bus.sel_next = 1'b1;
      tick();
      check($sformatf("press%0d_chan", p), 64'(bus.cur_channel), 64'((p + 1) % 4));
      bus.sel_next = 1'b0;
      tick();
    end

    // A held button advances once.
    bus.sel_next = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.sel_next = 1'b0;
    tick();
    check("held_chan", 64'(bus.cur_channel), 64'd1);

    // Freeze blocks capture; releasing it lets a reload through.
    bus.freeze = 1'b1;
    bus.ch_data = {4{32'hDEADBEEF}};
    bus.ch_load = 4'hF;
    tick();
    bus.ch_load = 4'h0;
    tick();
    check("freeze_seg", 64'(bus.seg_L), 64'(last_seg));
    bus.freeze = 1'b0;
    bus.ch_load = 4'hF;
    tick();
    bus.ch_load = 4'h0;
    tick();
    check("unfreeze_seg", 64'(bus.seg_L), 64'(tbl[0].seg));

    // Blink on digit 0: half of any 16 consecutive cycles are blank.
    bus.blink_mask = 8'h01;
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.seg_L[6:0] == 7'h7F) blanks++;
    end
`ifdef HEXDISP_BLINK_EN
    expb = 8;
`else
    expb = 0;
`endif
    check("blink_count", 64'(blanks), 64'(expb));

    // Auto cycling, and a press mid-count restarting the interval.
    bus.auto_en = 1'b1;
    c0 = int'(bus.cur_channel);
    for (int i = 0; i < 7; i++) tick();
    check("auto_pre", 64'(bus.cur_channel), 64'(c0));
    tick();
    check("auto_adv", 64'(bus.cur_channel), 64'((c0 + 1) % 4));
    tick(); tick(); tick();
    bus.sel_next = 1'b1;
    tick();
    bus.sel_next = 1'b0;
    check("auto_press", 64'(bus.cur_channel), 64'((c0 + 2) % 4));
    for (int i = 0; i < 7; i++) tick();
    check("auto_restart_pre", 64'(bus.cur_channel), 64'((c0 + 2) % 4));
    tick();
    check("auto_restart_adv", 64'(bus.cur_channel), 64'((c0 + 3) % 4));

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        r = $urandom;
        r = r >> (4 * $urandom_range(0, 8));
        bus.ch_data[32*i +: 32] = r;
      end
      bus.ch_load = 4'($urandom);
      bus.freeze = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) bus.sel_next = ~bus.sel_next;
      if ($urandom_range(0, 49) == 0) bus.auto_en = ~bus.auto_en;
      if ($urandom_range(0, 19) == 0) bus.blank_lz = ~bus.blank_lz;
      if ($urandom_range(0, 19) == 0) bus.blink_mask = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
